pooling_output_scheduler: RTL and testbench

Sequences the pooling-layer output buffer. In FILL it accepts pooled rows from the pooling core, drives the feature index, and generates buffer write strobes and addresses. In DRAIN it reads the buffer feature-major and presents the rows to the next layer over a valid/ready handshake. It sits between the pooling core and the next convolution stage's input loader.

---
 rtl/pooling_output_scheduler_pkg.sv | 27 ++
 rtl/pool_feat_row_counter.sv | 58 +++++
 rtl/pooling_output_scheduler.sv | 121 ++++++++++++
 tb/tb_pooling_output_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pooling_output_scheduler_pkg.sv
// Shared pooling-layer definitions: frame geometry, scheduler states and
// the buffer address map used by both the fill and drain sides.
package pooling_output_scheduler_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int OUTPUT_SIZE   = 3;
    localparam int TOTAL_FEATURE = 6;
    localparam int ROWS          = 3;
    localparam int FEAT_W        = $clog2(TOTAL_FEATURE);
    localparam int ROW_W         = $clog2(ROWS);
    localparam int ADDR_W        = $clog2(TOTAL_FEATURE * ROWS);
    localparam int BEAT_W        = OUTPUT_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Buffer is laid out feature-major: each feature owns ROWS consecutive slots.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [FEAT_W-1:0] feat,
                                                  input logic [ROW_W-1:0]  row);
        return ADDR_W'(feat) * ADDR_W'(ROWS) + ADDR_W'(row);
    endfunction

endpackage

// File: rtl/pool_feat_row_counter.sv
// Nested feature/row counter. feat_inner_i selects which index steps on
// every increment; the other one steps when the inner index wraps.
module pool_feat_row_counter
    import pooling_output_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic              feat_inner_i,
    output logic [FEAT_W-1:0] feat_o,
    output logic [ROW_W-1:0]  row_o,
    output logic              wrap_o,
    output logic              last_o
);

    logic [FEAT_W-1:0] feat_q, feat_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              feat_max, row_max;

    assign feat_max = (feat_q == FEAT_W'(TOTAL_FEATURE - 1));
    assign row_max  = (row_q  == ROW_W'(ROWS - 1));

    // Next-count: clear beats increment; outer index steps on inner wrap.
    always_comb begin
        feat_d = feat_q;
        row_d  = row_q;
        if (clr_i) begin
            feat_d = '0;
            row_d  = '0;
        end else if (inc_i) begin
            if (feat_inner_i) begin
                feat_d = feat_max ? '0 : feat_q + FEAT_W'(1);
                if (feat_max) row_d = row_max ? '0 : row_q + ROW_W'(1);
            end else begin
                row_d = row_max ? '0 : row_q + ROW_W'(1);
                if (row_max) feat_d = feat_max ? '0 : feat_q + FEAT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q <= '0;
            row_q  <= '0;
        end else begin
            feat_q <= feat_d;
            row_q  <= row_d;
        end
    end

    assign feat_o = feat_q;
    assign row_o  = row_q;
    assign wrap_o = inc_i & (feat_inner_i ? feat_max : row_max);
    assign last_o = feat_max & row_max;

endmodule

// File: rtl/pooling_output_scheduler.sv
// Pooling output buffer scheduler: fills the buffer feature-inner from the
// pooling core, then drains it feature-major to the next layer.
module pooling_output_scheduler
    import pooling_output_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FEAT_W-1:0] feature_idx,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [BEAT_W-1:0] buf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic              reads_left_q, reads_left_d;
    logic              out_valid_q, out_valid_d;
    logic              cnt_clr, cnt_inc, cnt_feat_inner;
    logic              cnt_wrap, cnt_last;
    logic [FEAT_W-1:0] feat_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [ADDR_W-1:0] cur_addr;

    // One counter serves both phases; order flips between fill and drain.
    pool_feat_row_counter u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (cnt_clr),
        .inc_i        (cnt_inc),
        .feat_inner_i (cnt_feat_inner),
        .feat_o       (feat_cnt),
        .row_o        (row_cnt),
        .wrap_o       (cnt_wrap),
        .last_o       (cnt_last)
    );

    assign cur_addr = addr_of(feat_cnt, row_cnt);

    // Next-state and strobes; abort overrides whatever the state decided.
    always_comb begin
        state_d        = state_q;
        reads_left_d   = reads_left_q;
        out_valid_d    = out_valid_q;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        cnt_feat_inner = 1'b1;
        in_ready       = 1'b0;
        buf_wr_en      = 1'b0;
        buf_rd_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    cnt_clr = 1'b1;
                end
            end
            FILL: begin
                in_ready  = 1'b1;
                buf_wr_en = in_valid;
                cnt_inc   = in_valid;
                // wrap on the outer-most beat marks the final write
                if (cnt_wrap && cnt_last) begin
                    state_d      = DRAIN;
                    cnt_clr      = 1'b1;
                    reads_left_d = 1'b1;
                    out_valid_d  = 1'b0;
                end
            end
            DRAIN: begin
                cnt_feat_inner = 1'b0;
                buf_rd_en      = reads_left_q & (!out_valid_q | out_ready);
                cnt_inc        = buf_rd_en;
                if (cnt_wrap && cnt_last) reads_left_d = 1'b0;
                out_valid_d = buf_rd_en ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
                if (out_valid_q && out_ready && !reads_left_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d      = IDLE;
            cnt_clr      = 1'b1;
            out_valid_d  = 1'b0;
            reads_left_d = 1'b0;
        end
    end

    // State, read-pending and output-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            reads_left_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            reads_left_q <= reads_left_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign buf_wr_addr = cur_addr;
    assign buf_rd_addr = cur_addr;
    assign feature_idx = (state_q == FILL || state_q == DRAIN) ? feat_cnt : '0;
    assign out_valid   = out_valid_q;
    assign out_data    = buf_rd_data;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_pooling_output_scheduler.sv
// Directed bench for the pooling output scheduler with a behavioural buffer.
module tb_pooling_output_scheduler;
    import pooling_output_scheduler_pkg::*;

    localparam int NBEAT = TOTAL_FEATURE * ROWS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic              in_ready, buf_wr_en, buf_rd_en, out_valid, busy, done;
    logic [FEAT_W-1:0] feature_idx;
    logic [ADDR_W-1:0] buf_wr_addr, buf_rd_addr;
    logic [BEAT_W-1:0] buf_rd_data = '0;
    logic [BEAT_W-1:0] out_data;
    logic [BEAT_W-1:0] wr_pattern = '0;
    logic [BEAT_W-1:0] mem [0:NBEAT-1];
    int                wr_cnt = 0;
    int                errors = 0, checks = 0;
    int                base, nb, nd;

    pooling_output_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .feature_idx(feature_idx),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Buffer model: synchronous write, one-cycle read that holds until next read.
    always @(posedge clk) begin
        if (buf_wr_en) begin
            mem[buf_wr_addr] <= wr_pattern;
            wr_cnt <= wr_cnt + 1;
        end
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    function automatic logic [BEAT_W-1:0] pat(input int k);
        logic [31:0] kk;
        kk = k;
        return {32'hA000_0000 + kk, 32'hB000_0000 + kk, 32'hC000_0000 + kk};
    endfunction

    // Address a = f*ROWS + r was written by fill beat r*TOTAL_FEATURE + f.
    function automatic logic [BEAT_W-1:0] exp_data(input int a);
        return pat((a % ROWS) * TOTAL_FEATURE + a / ROWS);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs start plus 18 fill beats; optionally checks each write and pokes start mid-fill.
    task automatic fill_frame(input bit chk_on, input bit poke_start);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NBEAT; k++) begin
            in_valid   = 1'b1;
            wr_pattern = pat(k);
            if (poke_start && k == 8) start = 1'b1;
            #1;
            if (chk_on) begin
                chk("fill_in_ready", in_ready, 1);
                chk("fill_wr_en", buf_wr_en, 1);
                chk("fill_wr_addr", buf_wr_addr, (k % TOTAL_FEATURE) * ROWS + k / TOTAL_FEATURE);
                chk("fill_feature_idx", feature_idx, k % TOTAL_FEATURE);
            end
            tick();
            start = 1'b0;
        end
        #1;
        chk("in_ready_drop", in_ready, 0);
        chk("no_wr_after_fill", buf_wr_en, 0);
        in_valid = 1'b0;
    endtask

    // Drains with a repeating 4-cycle ready pattern; stop_after>0 returns once that beat is accepted.
    task automatic drain(input logic [3:0] rdy, input int stop_after, output int beats, output int dones);
        int rdcnt, first_v, last_acc, done_cyc;
        bit stalled, finished;
        logic [BEAT_W-1:0] held;
        beats = 0; dones = 0; rdcnt = 0; first_v = -1; last_acc = -1; done_cyc = -1;
        stalled = 1'b0; finished = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            out_ready = rdy[cyc % 4];
            #1;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (buf_rd_en) begin
                chk("rd_addr", buf_rd_addr, rdcnt);
                rdcnt++;
            end
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (stalled) chk("stall_hold", out_data, held);
                chk("out_data", out_data, exp_data(beats));
                held    = out_data;
                stalled = !out_ready;
                if (out_ready) begin
                    beats++;
                    last_acc = cyc;
                end
            end else begin
                stalled = 1'b0;
            end
            if (stop_after > 0 && beats == stop_after) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        chk("drain_timeout", finished, 1);
        if (stop_after == 0) begin
            chk("drain_beats", beats, NBEAT);
            chk("drain_reads", rdcnt, NBEAT);
            chk("done_count", dones, 1);
            chk("done_after_last", done_cyc, last_acc + 1);
            if (rdy == 4'hF) chk("full_throughput", last_acc - first_v, NBEAT - 1);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        // reset values
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_feature_idx", feature_idx, 0);
        chk("rst_rd_en", buf_rd_en, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        #1;
        chk("idle_wr_en", buf_wr_en, 0);
        chk("idle_in_ready", in_ready, 0);
        tick();
        chk("idle_stays", busy, 0);
        in_valid = 1'b0;

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        // reset mid-fill after 7 beats
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            tick();
        end
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        tick();
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_feature_idx", feature_idx, 0);
        chk("midrst_wr_en", buf_wr_en, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();

        // frame 1: checked fill with a stray start, full-rate drain
        base = wr_cnt;
        fill_frame(1'b1, 1'b1);
        chk("frame1_writes", wr_cnt - base, NBEAT);
        drain(4'hF, 0, nb, nd);

        // frame 2: ready pattern 1,0,0,1
        base = wr_cnt;
        fill_frame(1'b0, 1'b0);
        chk("frame2_writes", wr_cnt - base, NBEAT);
        drain(4'b1001, 0, nb, nd);

        // frame 3: abort on drain beat 5
        fill_frame(1'b0, 1'b0);
        drain(4'hF, 5, nb, nd);
        chk("abort_beat", nb, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_feature_idx", feature_idx, 0);
        tick();
        chk("abort_no_done", done, 0);

        // frame 4: clean frame after abort
        base = wr_cnt;
        fill_frame(1'b1, 1'b0);
        chk("frame4_writes", wr_cnt - base, NBEAT);
        drain(4'hF, 0, nb, nd);
        tick();
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
